seg_scan_ctrl: RTL
==================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexes NUM_DIGITS BCD digits of the stopwatch display onto one shared
//  BCD-to-seven-segment decoder. Drives the decoder's 4-bit input and per-digit
//  common enables, with dead time between digits, leading-zero suppression and
//  tear-free frame-synchronous update of the displayed value.
// PARAMETERS
//  NUM_DIGITS        4      digits scanned per frame (>=2)
//  DWELL_CYCLES      50000  clk cycles one digit is lit (>=1)
//  BLANK_CYCLES      500    clk cycles of dead time before each digit (>=1)
//  DIGIT_ACTIVE_LOW  1      1: digit_en low = lit; 0: high = lit
// PORTS
//  clk        in   1             system clock, single clock domain
//  rst_n      in   1             asynchronous active-low reset
//  enable     in   1             1 = scan; 0 = display dark
//  digits_in  in   4*NUM_DIGITS  BCD digits; [3:0] = digit 0 (least significant)
//  dp_in      in   NUM_DIGITS    decimal point per digit
//  load       in   1             1-cycle strobe: capture digits_in/dp_in
//  blank_lz   in   1             1 = suppress leading zeros
//  load_ack   out  1             1-cycle pulse: captured value now displayed
//  bcd_out    out  4             to decoder input (bit 3 = MSB)
//  dp_out     out  1             decimal point of current digit
//  digit_en   out  NUM_DIGITS    digit commons, polarity per DIGIT_ACTIVE_LOW
//  frame_start out 1             1-cycle pulse on entry to BLANK for digit 0
// BEHAVIOUR
//  Reset: state IDLE, idx=0, staging/shadow=0, pending=0, bcd_out=0, dp_out=0,
//   digit_en all off, load_ack=0, frame_start=0.
//  States: IDLE (all off) -> BLANK (all off, BLANK_CYCLES) -> DRIVE (digit idx on,
//   DWELL_CYCLES) -> BLANK with idx=(idx+1) mod NUM_DIGITS. enable=0 in any state ->
//   IDLE next edge, idx=0, all off. IDLE & enable=1 -> BLANK idx 0 next edge.
//  Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
//  bcd_out/dp_out take shadow[idx] on BLANK entry and hold through DRIVE, so the
//   decoder settles before the digit is lit.
//  load: staging <= digits_in/dp_in, pending <= 1; later load before transfer
//   overwrites staging (last wins). Transfer staging->shadow on BLANK entry for
//   idx 0 (same edge as frame_start), or on next edge if in IDLE; load_ack
//   pulses the cycle after transfer, pending cleared. load coincident with transfer
//   edge: transfer uses the old staging, new load stays pending.
//  Digit suppressed (enable kept off in DRIVE, timing unchanged) when: shadow value
//   >9 (invalid BCD); or blank_lz=1 and digit is 0, dp=0 and all more significant
//   digits are suppressed zeros. Digit 0 is never zero-suppressed.
//  Counter: one down-counter, width $clog2(max(DWELL,BLANK)+1), reloaded on each
//   state entry; transition when it reaches 1. Reset mid-frame: immediate dark.
// STRUCTURE
//  Package seg_scan_pkg: state enum {IDLE,BLANK,DRIVE}, BCD_MAX=4'd9,
//   function digit_off(active_low) giving inactive enable level.
//  Sub-module seg_scan_timer: loadable down-counter with terminal flag.
//  Shared decoder instantiated at top level, not inside this block.
// TESTING (NUM_DIGITS=4, DWELL=4, BLANK=2)
//  Reset: rst_n=0 mid-DRIVE -> digit_en=4'b1111, bcd_out=0, load_ack=0 same cycle.
//  Scan: load 0x1234, enable=1 -> digit order 4,3,2,1; each lit exactly 4 cycles
//   after 2 dark cycles; frame_start every 24 cycles.
//  Tear-free: load 0x5678 mid-frame -> no digit shows 5-8 before next frame_start;
//   load_ack one cycle after that frame_start.
//  Leading zeros: 0x0005, blank_lz=1 -> only digit 0 lit; dp_in=4'b0100 -> digits
//   2,1,0 lit (0,0,5).
//  Invalid: digit 1 = 4'hC -> digit 1 slot stays dark, timing unchanged.
//  Enable drop mid-DRIVE -> all off next cycle; reassert -> frame_start, idx 0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
//   Shared types and constants for the seven-segment scan controller.
//   - scan_state_t : scan FSM states (IDLE, BLANK, DRIVE)
//   - BCD_MAX      : largest valid BCD digit value
//   - digit_off()  : inactive level of a digit common for a given polarity
//   - bcd_invalid(): true when a nibble is not a legal BCD digit
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Active-low commons are dark when driven high, active-high when driven low.
  function automatic logic digit_off(input logic active_low);
    return active_low;
  endfunction

  function automatic logic bcd_invalid(input logic [3:0] value);
    return (value > BCD_MAX);
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer
//   Loadable down-counter shared by every scan state. Loading takes priority
//   over counting; the counter stops at zero. done flags the last cycle of the
//   loaded interval (count == 1).
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload count with load_val this edge
//   load_val   : interval length in cycles
//   count      : current counter value
//   done       : count == 1 (interval expires at the next edge)
module seg_scan_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         done
);

  // Counter register: reload on request, otherwise count down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexes NUM_DIGITS BCD digits onto one shared seven-segment
//   decoder. Each digit slot is BLANK_CYCLES dark followed by DWELL_CYCLES lit;
//   the decoder input changes at the start of the dark phase so it has settled
//   before the common is enabled. New values are staged by load and copied to
//   the displayed shadow copy only at the start of a frame, so a frame never
//   shows a mix of old and new digits.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : 1 = scan, 0 = dark (FSM held in IDLE)
//   digits_in   : BCD digits, [3:0] = digit 0 (least significant)
//   dp_in       : decimal point per digit
//   load        : 1-cycle strobe capturing digits_in / dp_in into staging
//   blank_lz    : 1 = suppress leading zeros
//   load_ack    : 1-cycle pulse once a captured value is on the display
//   bcd_out     : decoder input for the current digit
//   dp_out      : decimal point for the current digit
//   digit_en    : digit commons, polarity set by DIGIT_ACTIVE_LOW
//   frame_start : 1-cycle pulse on entry to BLANK for digit 0
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int DWELL_CYCLES     = 50000,
  parameter int BLANK_CYCLES     = 500,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic                    load_ack,
  output logic [3:0]              bcd_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam logic              OFF      = digit_off(DIGIT_ACTIVE_LOW);
  localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]     BLANK_LD = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0]     DWELL_LD = CW'(DWELL_CYCLES);

  scan_state_t state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;

  logic [4*NUM_DIGITS-1:0] staging_dig, shadow_dig, shadow_dig_nxt;
  logic [NUM_DIGITS-1:0]   staging_dp, shadow_dp, shadow_dp_nxt;
  logic                    pending, pending_nxt;
  logic                    ack_pend;

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic [CW-1:0] tmr_count;
  logic          tmr_done;

  logic                  blank_entry;
  logic                  frame_nxt;
  logic                  transfer;
  logic [NUM_DIGITS-1:0] supp;
  logic [NUM_DIGITS-1:0] en_nxt;
  logic [3:0]            bcd_nxt;
  logic                  dp_nxt;
  logic                  lz_run;
  logic                  lz_here;
  logic [3:0]            lz_digit;

  seg_scan_timer #(
    .W (CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  // Next-state logic; the timer is reloaded on every state entry.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tmr_load  = 1'b0;
    tmr_val   = BLANK_LD;
    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          tmr_load  = 1'b1;
          tmr_val   = BLANK_LD;
        end
        BLANK: begin
          if (tmr_done) begin
            state_nxt = DRIVE;
            tmr_load  = 1'b1;
            tmr_val   = DWELL_LD;
          end else begin
            state_nxt = BLANK;
          end
        end
        DRIVE: begin
          if (tmr_done) begin
            state_nxt = BLANK;
            idx_nxt   = (idx == LAST_IDX) ? '0 : idx + IW'(1);
            tmr_load  = 1'b1;
            tmr_val   = BLANK_LD;
          end else begin
            state_nxt = DRIVE;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Frame-synchronous transfer of staged value and load bookkeeping.
  always_comb begin
    blank_entry = tmr_load && (state_nxt == BLANK);
    frame_nxt   = blank_entry && (idx_nxt == '0);
    // In IDLE nothing is displayed, so a pending value may move at once.
    transfer    = pending && ((state == IDLE) || frame_nxt);
    if (transfer) begin
      shadow_dig_nxt = staging_dig;
      shadow_dp_nxt  = staging_dp;
    end else begin
      shadow_dig_nxt = shadow_dig;
      shadow_dp_nxt  = shadow_dp;
    end
    // A load on the transfer edge itself stays pending for the next frame.
    if (load) begin
      pending_nxt = 1'b1;
    end else if (transfer) begin
      pending_nxt = 1'b0;
    end else begin
      pending_nxt = pending;
    end
  end

  // Suppression mask: invalid BCD, or a zero run from the most significant end.
  always_comb begin
    supp     = '0;
    lz_run   = blank_lz;
    lz_here  = 1'b0;
    lz_digit = 4'd0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_digit = shadow_dig_nxt[4*i +: 4];
      lz_here  = lz_run && (lz_digit == 4'd0) && !shadow_dp_nxt[i];
      supp[i]  = bcd_invalid(lz_digit) || lz_here;
      lz_run   = lz_here;
    end
    supp[0] = bcd_invalid(shadow_dig_nxt[3:0]);
  end

  // Output next values: decoder input changes on BLANK entry, common lit in DRIVE.
  always_comb begin
    if (blank_entry) begin
      bcd_nxt = shadow_dig_nxt[{idx_nxt, 2'b00} +: 4];
      dp_nxt  = shadow_dp_nxt[idx_nxt];
    end else begin
      bcd_nxt = bcd_out;
      dp_nxt  = dp_out;
    end
    en_nxt = {NUM_DIGITS{OFF}};
    if ((state_nxt == DRIVE) && !supp[idx_nxt]) begin
      en_nxt[idx_nxt] = ~OFF;
    end else begin
      en_nxt = {NUM_DIGITS{OFF}};
    end
  end

  // State, digit index and value registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      staging_dig <= '0;
      staging_dp  <= '0;
      shadow_dig  <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      ack_pend    <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      staging_dig <= load ? digits_in : staging_dig;
      staging_dp  <= load ? dp_in : staging_dp;
      shadow_dig  <= shadow_dig_nxt;
      shadow_dp   <= shadow_dp_nxt;
      pending     <= pending_nxt;
      ack_pend    <= transfer;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out     <= 4'd0;
      dp_out      <= 1'b0;
      digit_en    <= {NUM_DIGITS{OFF}};
      frame_start <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      bcd_out     <= bcd_nxt;
      dp_out      <= dp_nxt;
      digit_en    <= en_nxt;
      frame_start <= frame_nxt;
      load_ack    <= ack_pend;
    end
  end

endmodule
